// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronised rx, bit-timing FSM, holding storage and sticky error flags.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_receiver #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 52
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic [2:0]           rx_count,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   rx_meta_q, rx_sync_q;
    logic                   overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                   push, tick, frame_set, overrun_set;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        tick      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle:  if (!rx_sync_q) state_d = StStart;
            StStart: if (cnt_q == HalfLast) state_d = rx_sync_q ? StIdle : StData;
            StData: begin
                if (cnt_q == BitLast) begin
                    tick    = 1'b1;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    if (rx_sync_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StWaitIdle;
                    end
                end
            end
            StWaitIdle: if (rx_sync_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Restart the bit timer on every state entry and after each data sample.
        cnt_d = (state_d != state_q || tick) ? '0 : cnt_q + CntW'(1);
    end

    always_comb begin
        overrun_d   = clr_err ? 1'b0 : overrun_q;
        frame_err_d = clr_err ? 1'b0 : frame_err_q;
        if (overrun_set) overrun_d = 1'b1;
        if (frame_set) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [DATA_BITS-1:0] mem_q [4];
    logic [DATA_BITS-1:0] mem_d [4];
    logic [1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]           fcnt_q, fcnt_d;
    logic                 pop, wr, full;

    always_comb begin
        full        = (fcnt_q == 3'd4);
        pop         = rd_en && (fcnt_q != 3'd0);
        // A simultaneous pop frees the head slot, so a full FIFO can still accept.
        wr          = push && (!full || pop);
        overrun_set = push && full && !pop;
        mem_d       = mem_q;
        if (wr) mem_d[wptr_q] = shift_q;
        wptr_d = wr ? wptr_q + 2'd1 : wptr_q;
        rptr_d = pop ? rptr_q + 2'd1 : rptr_q;
        fcnt_d = fcnt_q;
        if (wr && !pop) fcnt_d = fcnt_q + 3'd1;
        if (!wr && pop) fcnt_d = fcnt_q - 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign rx_data  = mem_q[rptr_q];
    assign rx_valid = (fcnt_q != 3'd0);
    assign rx_count = fcnt_q;
`else
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;

    always_comb begin
        hold_d      = hold_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;
        if (push) begin
            if (!valid_q || rd_en) begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (rd_en && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign rx_data  = hold_q;
    assign rx_valid = valid_q;
    assign rx_count = {2'b00, valid_q};
`endif

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit-by-bit and received bytes checked
// against a queue of expected bytes in arrival order.
module tb_uart_receiver;

    localparam int unsigned Cpb = 52;

    logic       clk = 1'b0;
    logic       reset, rx, rd_en, clr_err;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err, busy;
    logic [2:0] rx_count;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_receiver dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_count (rx_count),
        .overrun  (overrun),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Every task is entered and left 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (Cpb) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (Cpb) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({rx_valid, rx_count, overrun, frame_err, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {rx_valid, rx_count, overrun, frame_err, busy});
        end
        checks++; if (rx_data !== 8'h00) begin
            failures++; $display("FAIL reset_data: got %h expected 00", rx_data);
        end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(8'h48);
        fork
            send_frame(8'h48, 1'b1);
            begin
                repeat (300) @(posedge clk);
                #1;
                checks++; if (busy !== 1'b1) begin
                    failures++; $display("FAIL basic_busy_mid: got %b expected 1", busy);
                end
                repeat (196) @(posedge clk);
                #1;
                checks++; if (rx_valid !== 1'b0) begin
                    failures++; $display("FAIL basic_valid_early: got %b expected 0", rx_valid);
                end
                @(posedge clk);
                #1;
                checks++; if (rx_valid !== 1'b1 || rx_count !== 3'd1) begin
                    failures++;
                    $display("FAIL basic_valid_496: got valid=%b count=%0d expected 1/1",
                             rx_valid, rx_count);
                end
                checks++; if (busy !== 1'b0) begin
                    failures++; $display("FAIL basic_busy_496: got %b expected 0", busy);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL basic_data: got %h expected none", rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rx_data !== exp_b) begin
                        failures++; $display("FAIL basic_data: got %h expected %h", rx_data, exp_b);
                    end
                end
                pulse_rd();
                checks++; if (rx_valid !== 1'b0 || rx_count !== 3'd0) begin
                    failures++;
                    $display("FAIL basic_pop: got valid=%b count=%0d expected 0/0",
                             rx_valid, rx_count);
                end
            end
        join
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin
            failures++; $display("FAIL glitch_busy: got %b expected 1", busy);
        end
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if ({busy, rx_valid, overrun, frame_err} !== 4'b0) begin
            failures++;
            $display("FAIL glitch_quiet: got %b expected 0000", {busy, rx_valid, overrun, frame_err});
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);
        checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL ferr_set: got ferr=%b valid=%b expected 1/0", frame_err, rx_valid);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin
            failures++; $display("FAIL ferr_wait_idle: got %b expected 1", busy);
        end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL ferr_release: got %b expected 0", busy);
        end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin
            failures++; $display("FAIL ferr_clear: got %b expected 0", frame_err);
        end
    endtask

`ifndef UART_RX_FIFO_EN
    task automatic test_overrun();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++; if (overrun !== 1'b1 || rx_count !== 3'd1) begin
            failures++;
            $display("FAIL ovr_set: got ovr=%b count=%0d expected 1/1", overrun, rx_count);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL ovr_kept: got %h expected none", rx_data);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin
                failures++; $display("FAIL ovr_kept: got %h expected %h", rx_data, exp_b);
            end
        end
        pulse_rd();
        pulse_clr();
        checks++; if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: got ovr=%b valid=%b expected 0/0", overrun, rx_valid);
        end
        // Second pass: pop coincides with the stop sample of the second frame.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (496) @(posedge clk);
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL ovr2_first: got %h expected none", rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rx_data !== exp_b) begin
                        failures++; $display("FAIL ovr2_first: got %h expected %h", rx_data, exp_b);
                    end
                end
                exp_q.push_back(8'h22);
                pulse_rd();
                checks++; if (overrun !== 1'b0 || rx_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL ovr2_flags: got ovr=%b valid=%b expected 0/1", overrun, rx_valid);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL ovr2_second: got %h expected none", rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rx_data !== exp_b) begin
                        failures++; $display("FAIL ovr2_second: got %h expected %h", rx_data, exp_b);
                    end
                end
                pulse_rd();
            end
        join
    endtask
`else
    task automatic test_fifo();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'hA0 + 8'(i));
            send_frame(8'hA0 + 8'(i), 1'b1);
        end
        checks++; if (rx_count !== 3'd4 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL fifo_full: got count=%0d ovr=%b expected 4/1", rx_count, overrun);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (exp_q.size() == 0 || rx_valid !== 1'b1) begin
                failures++; $display("FAIL fifo_read: got %h valid=%b expected entry", rx_data, rx_valid);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_data !== exp_b) begin
                    failures++; $display("FAIL fifo_read: got %h expected %h", rx_data, exp_b);
                end
            end
            pulse_rd();
        end
        checks++; if (rx_valid !== 1'b0 || rx_count !== 3'd0) begin
            failures++;
            $display("FAIL fifo_empty: got valid=%b count=%0d expected 0/0", rx_valid, rx_count);
        end
        pulse_clr();
    endtask
`endif

    task automatic test_back_to_back();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3A);
        fork
            begin
                send_frame(8'hC3, 1'b1);
                send_frame(8'h3A, 1'b1);
            end
            for (int k = 0; k < 2; k++) begin
                int n = 0;
                while (!rx_valid && n < 1200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (!rx_valid || exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_arrive: got valid=%b expected 1", rx_valid);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rx_data !== exp_b) begin
                        failures++; $display("FAIL b2b_data: got %h expected %h", rx_data, exp_b);
                    end
                end
                pulse_rd();
            end
        join
        checks++; if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got ovr=%b valid=%b expected 0/0", overrun, rx_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        rx = 1'b0;
        repeat (Cpb + Cpb + 40) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || rx_valid !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre: got busy=%b valid=%b expected 1/1", busy, rx_valid);
        end
        reset = 1'b1;
        #1;
        checks++; if ({rx_valid, rx_count, overrun, frame_err, busy} !== 6'b0 || rx_data !== 8'h00)
        begin
            failures++;
            $display("FAIL rstmid_clear: got flags=%b data=%h expected 000000/00",
                     {rx_valid, rx_count, overrun, frame_err, busy}, rx_data);
        end
        exp_q.delete();
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle: got busy=%b ferr=%b expected 0/0", busy, frame_err);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("FAIL rstmid_next: got valid=%b expected 1", rx_valid);
        end else begin
            exp_b = exp_q.pop_front();
            if (rx_data !== exp_b) begin
                failures++; $display("FAIL rstmid_next: got %h expected %h", rx_data, exp_b);
            end
        end
        pulse_rd();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
`ifndef UART_RX_FIFO_EN
        test_overrun();
`else
        test_fifo();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
